maze_frame_streamer: RTL and testbench

Synthesizable, parametrised renderer for the grid-world maze. Holds a wall bitmap and, on a start pulse, streams one cell code per transfer in row-major order over a valid/ready handshake. Codes are empty, agent, goal and wall. It sits between the RL agent core (which supplies agent and goal positions) and a UART or display sink, and replaces simulation-only printing with hardware output.

---
 rtl/maze_frame_streamer.sv | 167 ++++++++++++++++
 tb/tb_maze_frame_streamer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/maze_frame_streamer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | maze_frame_streamer: streams maze cell codes row-major over valid/ready.  |
// | Optional MAZE_STREAM_COORD_EN adds cell_row/cell_col outputs.             |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module maze_frame_streamer #(
  parameter int ROWS  = 10,
  parameter int COLS  = 10,
  parameter int POS_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [POS_W-1:0] agent_pos,
  input  logic [POS_W-1:0] goal_pos,
  input  logic             wall_we,
  input  logic [POS_W-1:0] wall_addr,
  input  logic             wall_din,
  output logic             busy,
  output logic             cell_valid,
  input  logic             cell_ready,
  output logic [1:0]       cell_code,
  output logic             cell_eol,
  output logic             cell_eof,
  output logic             frame_done
`ifdef MAZE_STREAM_COORD_EN
  ,
  output logic [POS_W-1:0] cell_row,
  output logic [POS_W-1:0] cell_col
`endif
);

  localparam int CELLS = ROWS * COLS;
  localparam logic [POS_W-1:0] C_LAST_IDX = POS_W'(CELLS - 1);
  localparam logic [POS_W-1:0] C_LAST_COL = POS_W'(COLS - 1);
  localparam logic [POS_W-1:0] C_ZERO     = '0;
  localparam logic [POS_W-1:0] C_ONE      = POS_W'(1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_STREAM = 2'd1, S_DONE = 2'd2} state_t;

  state_t           r_state;
  logic [POS_W-1:0] r_idx;
  logic [POS_W-1:0] r_col;
  logic [POS_W-1:0] r_agent;
  logic [POS_W-1:0] r_goal;
  logic [CELLS-1:0] r_walls;

  logic             w_load;
  logic             w_we_ok;
  logic [POS_W-1:0] w_idx_nx;
  logic [POS_W-1:0] w_col_nx;
  logic [POS_W-1:0] w_agent_nx;
  logic [POS_W-1:0] w_goal_nx;
  logic [CELLS-1:0] w_mask;
  logic [CELLS-1:0] w_walls_nx;
  logic [CELLS-1:0] w_wall_shift;
  logic [1:0]       w_code_nx;

  function automatic logic [1:0] code_of(input logic [POS_W-1:0] i,
                                         input logic [POS_W-1:0] a,
                                         input logic [POS_W-1:0] g,
                                         input logic             w);
    if (a == i)      return 2'd1;
    else if (g == i) return 2'd2;
    else if (w)      return 2'd3;
    else             return 2'd0;
  endfunction

  assign w_load     = (r_state == S_IDLE) && start;
  assign w_idx_nx   = w_load ? C_ZERO : (r_idx + C_ONE);
  assign w_col_nx   = (w_load || (r_col == C_LAST_COL)) ? C_ZERO : (r_col + C_ONE);
  assign w_agent_nx = w_load ? agent_pos : r_agent;
  assign w_goal_nx  = w_load ? goal_pos  : r_goal;

  // A write landing on the start edge must already be visible in cell 0's code.
  assign w_we_ok      = wall_we && !busy && (wall_addr <= C_LAST_IDX);
  assign w_mask       = CELLS'(1) << wall_addr;
  assign w_walls_nx   = !w_we_ok ? r_walls
                      : (wall_din ? (r_walls | w_mask) : (r_walls & ~w_mask));
  assign w_wall_shift = w_walls_nx >> w_idx_nx;
  assign w_code_nx    = code_of(w_idx_nx, w_agent_nx, w_goal_nx, w_wall_shift[0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_walls <= '0;
    else     r_walls <= w_walls_nx;
  end

`ifdef MAZE_STREAM_COORD_EN
  logic [POS_W-1:0] r_row;
  assign cell_row = r_row;
  assign cell_col = r_col;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_col      <= '0;
      r_agent    <= '0;
      r_goal     <= '0;
      busy       <= 1'b0;
      cell_valid <= 1'b0;
      cell_code  <= 2'd0;
      cell_eol   <= 1'b0;
      cell_eof   <= 1'b0;
      frame_done <= 1'b0;
`ifdef MAZE_STREAM_COORD_EN
      r_row      <= '0;
`endif
    end else begin
      frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_STREAM;
            r_agent    <= agent_pos;
            r_goal     <= goal_pos;
            r_idx      <= '0;
            r_col      <= '0;
            busy       <= 1'b1;
            cell_valid <= 1'b1;
            cell_code  <= w_code_nx;
            cell_eol   <= (w_col_nx == C_LAST_COL);
            cell_eof   <= (w_idx_nx == C_LAST_IDX);
`ifdef MAZE_STREAM_COORD_EN
            r_row      <= '0;
`endif
          end
        end
        S_STREAM: begin
          if (cell_ready) begin
            if (r_idx == C_LAST_IDX) begin
              r_state    <= S_DONE;
              r_idx      <= '0;
              r_col      <= '0;
              cell_valid <= 1'b0;
              cell_code  <= 2'd0;
              cell_eol   <= 1'b0;
              cell_eof   <= 1'b0;
              frame_done <= 1'b1;
`ifdef MAZE_STREAM_COORD_EN
              r_row      <= '0;
`endif
            end else begin
              r_idx     <= w_idx_nx;
              r_col     <= w_col_nx;
              cell_code <= w_code_nx;
              cell_eol  <= (w_col_nx == C_LAST_COL);
              cell_eof  <= (w_idx_nx == C_LAST_IDX);
`ifdef MAZE_STREAM_COORD_EN
              if (r_col == C_LAST_COL) r_row <= r_row + C_ONE;
`endif
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_maze_frame_streamer.sv
`default_nettype none
// Bench for maze_frame_streamer: frame-level model checked every cycle plus literal pins.
module tb_maze_frame_streamer;
  localparam int N = 100;

  logic clk = 1'b0, rst = 1'b1;
  logic start = 0, wall_we = 0, wall_din = 0, cell_ready = 0;
  logic [7:0] agent_pos = 0, goal_pos = 0, wall_addr = 0;
  logic busy, cell_valid, cell_eol, cell_eof, frame_done;
  logic [1:0] cell_code;

  logic start_s = 0, ready_s = 1;
  logic [7:0] zero8 = 0, goal_s = 8'd23;
  logic zero1 = 0;
  logic busy_s, valid_s, eol_s, eof_s, done_s;
  logic [1:0] code_s;
`ifdef MAZE_STREAM_COORD_EN
  logic [7:0] row_s, col_s;
`endif

  always #5 clk = ~clk;

  maze_frame_streamer dut (
    .clk(clk), .rst(rst), .start(start), .agent_pos(agent_pos), .goal_pos(goal_pos),
    .wall_we(wall_we), .wall_addr(wall_addr), .wall_din(wall_din), .busy(busy),
    .cell_valid(cell_valid), .cell_ready(cell_ready), .cell_code(cell_code),
    .cell_eol(cell_eol), .cell_eof(cell_eof), .frame_done(frame_done));

  maze_frame_streamer #(.ROWS(4), .COLS(6), .POS_W(8)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .agent_pos(zero8), .goal_pos(goal_s),
    .wall_we(zero1), .wall_addr(zero8), .wall_din(zero1), .busy(busy_s),
    .cell_valid(valid_s), .cell_ready(ready_s), .cell_code(code_s),
    .cell_eol(eol_s), .cell_eof(eof_s), .frame_done(done_s)
`ifdef MAZE_STREAM_COORD_EN
    , .cell_row(row_s), .cell_col(col_s)
`endif
  );

  int checks = 0, errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: is a frame running, which cell it is on, and the latched positions.
  bit m_active, m_done;
  int m_pos, m_agent, m_goal;
  bit m_wall [N];
  wire m_busy = m_active | m_done;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 0; m_done <= 0; m_pos <= 0; m_agent <= 0; m_goal <= 0;
      for (int i = 0; i < N; i++) m_wall[i] <= 0;
    end else begin
      m_done <= 0;
      if (wall_we && !m_busy && wall_addr < N) m_wall[wall_addr] <= wall_din;
      if (!m_busy && start) begin
        m_active <= 1; m_pos <= 0; m_agent <= agent_pos; m_goal <= goal_pos;
      end else if (m_active && cell_ready) begin
        if (m_pos == N - 1) begin m_active <= 0; m_done <= 1; m_pos <= 0; end
        else m_pos <= m_pos + 1;
      end
    end
  end

  function automatic int exp_code(input int i);
    if (m_agent == i) return 1;
    if (m_goal == i) return 2;
    return m_wall[i] ? 3 : 0;
  endfunction

  int frame_id = 0, obs_n = 0, eol_n = 0, eof_n = 0, done_cnt = 0;
  int obs_code [N];

  initial begin : compare
    int last_id;
    bit prev_stall;
    int prev_code, prev_eol, prev_eof;
    last_id = 0; prev_stall = 0; prev_code = 0; prev_eol = 0; prev_eof = 0;
    forever begin
      @(negedge clk);
      if (frame_id != last_id) begin
        last_id = frame_id; obs_n = 0; eol_n = 0; eof_n = 0;
      end
      chk("busy", busy, m_busy);
      chk("valid", cell_valid, m_active);
      chk("code", cell_code, m_active ? exp_code(m_pos) : 0);
      chk("eol", cell_eol, m_active && (m_pos % 10 == 9));
      chk("eof", cell_eof, m_active && (m_pos == N - 1));
      chk("frame_done", frame_done, m_done);
      if (prev_stall) begin
        chk("stall_code", cell_code, prev_code);
        chk("stall_eol", cell_eol, prev_eol);
        chk("stall_eof", cell_eof, prev_eof);
      end
      if (frame_done) done_cnt++;
      if (cell_valid && cell_ready && obs_n < N) begin
        obs_code[obs_n] = cell_code;
        if (cell_eol) eol_n++;
        if (cell_eof) eof_n++;
        obs_n++;
      end
      prev_stall = cell_valid && !cell_ready;
      prev_code = cell_code; prev_eol = cell_eol; prev_eof = cell_eof;
    end
  end

  int k_s = 0, done_s_n = 0;
  initial begin : compare_small
    forever begin
      @(negedge clk);
      if (done_s) done_s_n++;
      if (valid_s && ready_s) begin
        chk("s_code", code_s, (k_s == 0) ? 1 : (k_s == 23) ? 2 : 0);
        chk("s_eol", eol_s, (k_s % 6) == 5);
        chk("s_eof", eof_s, k_s == 23);
`ifdef MAZE_STREAM_COORD_EN
        chk("s_row", row_s, k_s / 6);
        chk("s_col", col_s, k_s % 6);
`endif
        k_s++;
      end
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic start_frame(input int ag, input int go);
    agent_pos = 8'(ag); goal_pos = 8'(go); start = 1; frame_id++;
    step();
    start = 0;
  endtask

  task automatic wait_idle(input bit random_ready);
    int n;
    n = 0;
    while (busy && n < 2000) begin
      if (random_ready) begin
        cell_ready = ($urandom_range(0, 2) != 0);
        start = ($urandom_range(0, 9) == 0);
        wall_we = (n == 30); wall_addr = 8'd20; wall_din = 1;
      end
      step(); n++;
    end
    start = 0; wall_we = 0; cell_ready = 1;
    chk("frame_timeout", busy, 0);
    step(); step();
  endtask

  task automatic write_wall(input int a, input bit d);
    wall_we = 1; wall_addr = 8'(a); wall_din = d;
    step();
    wall_we = 0;
  endtask

  initial begin
    int d0, cnt1, n;
    step(); step();
    chk("reset_busy", busy, 0);
    chk("reset_code", cell_code, 0);
    rst = 0;
    step();

    // Empty maze, agent in the corner, goal opposite.
    cell_ready = 1;
    start_frame(0, 99);
    wait_idle(0);
    chk("t1_count", obs_n, 100);
    chk("t1_first", obs_code[0], 1);
    chk("t1_last", obs_code[99], 2);
    chk("t1_mid", obs_code[45], 0);
    chk("t1_eol_n", eol_n, 10);
    chk("t1_eof_n", eof_n, 1);
    chk("t1_done", done_cnt, 1);

    // Walls with the agent sitting on one.
    write_wall(11, 1); write_wall(12, 1); write_wall(13, 1);
    start_frame(12, 50);
    wait_idle(0);
    chk("t2_c11", obs_code[11], 3);
    chk("t2_c12", obs_code[12], 1);
    chk("t2_c13", obs_code[13], 3);
    chk("t2_c50", obs_code[50], 2);
    chk("t2_c10", obs_code[10], 0);

    // Back-pressure, stray starts and a write while busy.
    d0 = done_cnt;
    start_frame(99, 0);
    wait_idle(1);
    chk("t3_count", obs_n, 100);
    chk("t3_done", done_cnt, d0 + 1);
    repeat (5) step();
    chk("t3_no_extra", busy, 0);
    chk("t3_done_after", done_cnt, d0 + 1);

    // Coincident positions, out-of-range agent, out-of-range wall write.
    start_frame(37, 37);
    wait_idle(0);
    chk("t4_same", obs_code[37], 1);
    write_wall(120, 1);
    start_frame(200, 5);
    wait_idle(0);
    cnt1 = 0;
    for (int i = 0; i < N; i++) if (obs_code[i] == 1) cnt1++;
    chk("t4_no_agent", cnt1, 0);
    chk("t4_wall12", obs_code[12], 3);
    chk("t4_wall20", obs_code[20], 0);
    chk("t4_goal", obs_code[5], 2);

    // Abort with reset mid-frame.
    d0 = done_cnt;
    start_frame(0, 99);
    n = 0;
    while (obs_n < 40 && n < 500) begin step(); n++; end
    chk("t5_reach40", obs_n, 40);
    rst = 1;
    @(negedge clk); #1;
    chk("t5_busy", busy, 0);
    chk("t5_valid", cell_valid, 0);
    chk("t5_code", cell_code, 0);
    chk("t5_eol", cell_eol, 0);
    chk("t5_eof", cell_eof, 0);
    chk("t5_fd", frame_done, 0);
    step();
    rst = 0;
    repeat (4) step();
    chk("t5_no_done", done_cnt, d0);
    start_frame(0, 99);
    wait_idle(0);
    chk("t5_count", obs_n, 100);
    chk("t5_wall_cleared", obs_code[11], 0);
    chk("t5_done", done_cnt, d0 + 1);

    // Small 4x6 instance.
    start_s = 1;
    step();
    start_s = 0;
    n = 0;
    while (busy_s && n < 200) begin step(); n++; end
    step(); step();
    chk("s_count", k_s, 24);
    chk("s_done", done_s_n, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
